// File: rtl/apb_cmd_master.sv
// APB requester: takes single read/write commands over valid/ready, runs the
// SETUP/ACCESS handshake with a bounded PREADY wait, and returns a response.
module apb_cmd_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  // state  | meaning
  // IDLE   | ready for a command; APB bus deselected
  // SETUP  | PSEL=1, PENABLE=0 for one cycle
  // ACCESS | PSEL=1, PENABLE=1, waiting for PREADY or timeout
  // RESP   | response held on rsp_* until rsp_ready
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam bit              TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_t              state_q, state_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= ST_IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    wait_cnt_d    = wait_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          pwrite_d   = cmd_write;
          paddr_d    = cmd_addr;
          pwdata_d   = cmd_wdata;
          psel_d     = 1'b1;
          wait_cnt_d = '0;
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        // PREADY is checked first so a completion on the expiry edge still wins
        if (PREADY) begin
          rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = ST_RESP;
        end else if (TO_EN && (wait_cnt_q == TO_LAST)) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with a small APB memory slave that can
// insert wait states, hang, or flag PSLVERR.
module tb_apb_cmd_master;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        cmd_valid, cmd_write, rsp_ready;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [31:0] PADDR, PWDATA, PRDATA;

  logic [31:0] mem [0:255];
  logic [31:0] last_wdata = 32'h0;
  int          acc_cnt = 0;
  int          wait_states = 0;
  bit          hang = 1'b0;
  bit          slverr_en = 1'b0;
  int          cyc = 0;
  int          pen_cnt = 0;
  int          n_pass = 0;
  int          n_total = 0;

  always #5 PCLK = ~PCLK;

  apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16), .CNT_W(8)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  // slave model
  assign PREADY  = PSEL && PENABLE && !hang && (acc_cnt >= wait_states);
  assign PRDATA  = (PSEL && !PWRITE) ? mem[PADDR[7:0]] : 32'h0;
  assign PSLVERR = slverr_en && PREADY;

  always @(posedge PCLK) begin
    cyc <= cyc + 1;
    if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (PSEL && PENABLE && PREADY && PWRITE) begin
      mem[PADDR[7:0]] <= PWDATA;
      last_wdata      <= PWDATA;
    end
  end

  always @(negedge PCLK) if (PENABLE) pen_cnt <= pen_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int acc, output bit ok);
    ok  = 1'b0;
    acc = cyc;
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin
        @(posedge PCLK); #1;
        acc = cyc;
        ok  = 1'b1;
        break;
      end
      @(negedge PCLK);
    end
    cmd_valid = 1'b0;
    n_total++;
    if (ok !== 1'b1) $display("FAIL cmd_accept: accepted=%0b required=1", ok);
    else n_pass++;
  endtask

  task automatic wait_rsp(input int max_cyc, output int rc);
    bit ok = 1'b0;
    rc = cyc;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge PCLK);
      if (rsp_valid) begin
        rc = cyc;
        ok = 1'b1;
        break;
      end
    end
    n_total++;
    if (ok !== 1'b1) $display("FAIL rsp_wait: rsp_valid seen=%0b required=1", ok);
    else n_pass++;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge PCLK); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_total++;
    if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout} !== 6'b0)
      $display("FAIL reset_ctrl: got=%b required=000000",
               {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout});
    else n_pass++;
    n_total++;
    if ({PADDR, PWDATA, rsp_rdata} !== 96'h0)
      $display("FAIL reset_data: paddr=%h pwdata=%h rdata=%h required=0", PADDR, PWDATA, rsp_rdata);
    else n_pass++;
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    n_total++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got=%b required=1", cmd_ready);
    else n_pass++;
  endtask

  task automatic test_write_zero_wait();
    int acc, rc;
    bit ok;
    wait_states = 0;
    send_cmd(1'b1, 32'h2, 32'hFFFF_FFFF, acc, ok);
    @(negedge PCLK);
    n_total++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {3'b101, 32'h2, 32'hFFFF_FFFF})
      $display("FAIL wr_setup: psel=%b pen=%b pw=%b paddr=%h pwdata=%h required 1/0/1/2/ffffffff",
               PSEL, PENABLE, PWRITE, PADDR, PWDATA);
    else n_pass++;
    @(negedge PCLK);
    n_total++;
    if ({PSEL, PENABLE, cmd_ready} !== 3'b110)
      $display("FAIL wr_access: psel/pen/cmd_ready=%b required=110", {PSEL, PENABLE, cmd_ready});
    else n_pass++;
    wait_rsp(10, rc);
    n_total++;
    if (rc + 1 - acc !== 3) $display("FAIL wr_latency: got=%0d required=3", rc + 1 - acc);
    else n_pass++;
    n_total++;
    if ({rsp_err, rsp_timeout, rsp_rdata, PSEL, PENABLE} !== {2'b00, 32'h0, 2'b00})
      $display("FAIL wr_rsp: err=%b to=%b rdata=%h psel=%b pen=%b required 0/0/0/0/0",
               rsp_err, rsp_timeout, rsp_rdata, PSEL, PENABLE);
    else n_pass++;
    n_total++;
    if (last_wdata !== 32'hFFFF_FFFF) $display("FAIL wr_slave_data: got=%h required=ffffffff", last_wdata);
    else n_pass++;
    handshake();
    @(negedge PCLK);
    n_total++;
    if ({rsp_valid, cmd_ready} !== 2'b01)
      $display("FAIL wr_release: rsp_valid/cmd_ready=%b required=01", {rsp_valid, cmd_ready});
    else n_pass++;
  endtask

  task automatic test_read_wait();
    int acc, rc, pen0;
    bit ok;
    wait_states = 3;
    pen0 = pen_cnt;
    send_cmd(1'b0, 32'h4, 32'h0, acc, ok);
    wait_rsp(20, rc);
    n_total++;
    if (rc + 1 - acc !== 6) $display("FAIL rd_latency: got=%0d required=6", rc + 1 - acc);
    else n_pass++;
    n_total++;
    if ({rsp_rdata, rsp_err, rsp_timeout} !== {32'hA5A5_1234, 2'b00})
      $display("FAIL rd_rsp: rdata=%h err=%b to=%b required a5a51234/0/0", rsp_rdata, rsp_err, rsp_timeout);
    else n_pass++;
    n_total++;
    if (pen_cnt - pen0 !== 4) $display("FAIL rd_penable_cycles: got=%0d required=4", pen_cnt - pen0);
    else n_pass++;
    handshake();
    wait_states = 0;
  endtask

  task automatic test_timeout();
    int acc, rc, pen0;
    bit ok;
    hang = 1'b1;
    pen0 = pen_cnt;
    send_cmd(1'b0, 32'h20, 32'h0, acc, ok);
    wait_rsp(40, rc);
    n_total++;
    if (rc + 1 - acc !== 18) $display("FAIL to_latency: got=%0d required=18", rc + 1 - acc);
    else n_pass++;
    n_total++;
    if ({PSEL, PENABLE, rsp_err, rsp_timeout, rsp_rdata} !== {4'b0011, 32'h0})
      $display("FAIL to_rsp: psel=%b pen=%b err=%b to=%b rdata=%h required 0/0/1/1/0",
               PSEL, PENABLE, rsp_err, rsp_timeout, rsp_rdata);
    else n_pass++;
    n_total++;
    if (pen_cnt - pen0 !== 16) $display("FAIL to_penable_cycles: got=%0d required=16", pen_cnt - pen0);
    else n_pass++;
    handshake();
    hang = 1'b0;
    send_cmd(1'b1, 32'h24, 32'h55, acc, ok);
    wait_rsp(10, rc);
    n_total++;
    if ({rc + 1 - acc, rsp_err, rsp_timeout} !== {32'd3, 2'b00})
      $display("FAIL to_recover: latency=%0d err=%b to=%b required 3/0/0", rc + 1 - acc, rsp_err, rsp_timeout);
    else n_pass++;
    handshake();
  endtask

  task automatic test_backpressure_slverr();
    int acc, rc;
    bit ok;
    bit held = 1'b1;
    slverr_en = 1'b1;
    send_cmd(1'b0, 32'h8, 32'h0, acc, ok);
    wait_rsp(10, rc);
    n_total++;
    if ({rsp_err, rsp_timeout, rsp_rdata} !== {2'b10, 32'h0BAD_F00D})
      $display("FAIL bp_rsp: err=%b to=%b rdata=%h required 1/0/0badf00d", rsp_err, rsp_timeout, rsp_rdata);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      if ({rsp_valid, rsp_err, cmd_ready} !== 3'b110) held = 1'b0;
      @(negedge PCLK);
    end
    n_total++;
    if (held !== 1'b1) $display("FAIL bp_hold: held=%b required=1", held);
    else n_pass++;
    slverr_en = 1'b0;
    handshake();
    @(negedge PCLK);
    n_total++;
    if ({rsp_valid, cmd_ready, rsp_err} !== 3'b011)
      $display("FAIL bp_release: valid/ready/err=%b required=011", {rsp_valid, cmd_ready, rsp_err});
    else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    int acc;
    bit ok;
    bit stale = 1'b0;
    hang = 1'b1;
    send_cmd(1'b0, 32'h30, 32'h0, acc, ok);
    @(negedge PCLK);
    @(negedge PCLK);
    n_total++;
    if (PENABLE !== 1'b1) $display("FAIL rst_pre_access: penable=%b required=1", PENABLE);
    else n_pass++;
    #1 PRESETn = 1'b0;
    #1;
    n_total++;
    if ({PSEL, PENABLE, rsp_valid} !== 3'b000)
      $display("FAIL rst_async: psel/pen/valid=%b required=000", {PSEL, PENABLE, rsp_valid});
    else n_pass++;
    @(negedge PCLK);
    PRESETn = 1'b1;
    hang = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge PCLK);
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || PSEL !== 1'b0) stale = 1'b1;
    end
    n_total++;
    if (stale !== 1'b0) $display("FAIL rst_no_stale: stale=%b required=0", stale);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, rc;
    bit got1 = 1'b0;
    bit ok2 = 1'b0;
    logic [1:0] rsp1 = 2'b11;
    acc1 = cyc;
    acc2 = cyc;
    rsp_ready = 1'b1;
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'h1;
    if (cmd_ready) begin
      @(posedge PCLK); #1;
      acc1 = cyc;
    end
    @(negedge PCLK);
    cmd_write = 1'b0; cmd_wdata = 32'h0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid && !got1) begin
        got1 = 1'b1;
        rsp1 = {rsp_err, rsp_timeout};
      end
      if (cmd_ready) begin
        @(posedge PCLK); #1;
        acc2 = cyc;
        ok2  = 1'b1;
        break;
      end
      @(negedge PCLK);
    end
    cmd_valid = 1'b0;
    n_total++;
    if ({ok2, got1, rsp1} !== 4'b1100)
      $display("FAIL b2b_first: accepted2=%b rsp1_seen=%b err/to=%b required 1/1/00", ok2, got1, rsp1);
    else n_pass++;
    n_total++;
    if (acc2 - acc1 !== 4) $display("FAIL b2b_spacing: got=%0d required=4", acc2 - acc1);
    else n_pass++;
    wait_rsp(10, rc);
    n_total++;
    if ({rsp_rdata, rsp_err} !== {32'h1, 1'b0})
      $display("FAIL b2b_read: rdata=%h err=%b required 00000001/0", rsp_rdata, rsp_err);
    else n_pass++;
    @(posedge PCLK); #1;
    rsp_ready = 1'b0;
    @(negedge PCLK);
    n_total++;
    if ({rsp_valid, cmd_ready} !== 2'b01)
      $display("FAIL b2b_idle: valid/ready=%b required=01", {rsp_valid, cmd_ready});
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[4] = 32'hA5A5_1234;
    mem[8] = 32'h0BAD_F00D;
    mem[16] = 32'hDEAD_BEEF;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
    rsp_ready = 1'b0;
    PRESETn = 1'b1;
    #1 PRESETn = 1'b0;
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_timeout();
    test_backpressure_slverr();
    test_reset_mid_access();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
